execute_multicycle_stage: RTL and testbench
===========================================

EXECUTE_MULTICYCLE_STAGE -- requirements
Module: execute_multicycle_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand, forwarding-slice and result width (legal 8..64, power of two).
REQ-002 Parameter FWD_SOURCES, default 4, SHALL set the number of forwarding data slices per operand (legal 1..6).
REQ-003 Parameter SEL_W, default $clog2(FWD_SOURCES+2), SHALL set operand-select width.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 IN_VALID  in  1  upstream presents an operation; IN_READY  out  1  stage can accept.
REQ-007 STALL  in  1  downstream hold; CLEAR  in  1  flush stage.
REQ-008 OP  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 MUL,11 MULHU; 12-15 reserved.
REQ-009 RS1_DATA, PC_IN, RS2_DATA, IMM_DATA  in  DATA_WIDTH each  primary operand sources.
REQ-010 FWD1_DATA, FWD2_DATA  in  FWD_SOURCES*DATA_WIDTH  flattened forwarding slices, slice k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 IN1_SELECT, IN2_SELECT  in  SEL_W  operand source select.
REQ-012 RD_ADDRESS_IN  in  5; RD_WRITE_ENABLE_IN  in  1  destination tag passed through.
REQ-013 OUT_VALID  out  1; RESULT_OUT  out  DATA_WIDTH; RD_ADDRESS_OUT  out  5; RD_WRITE_ENABLE_OUT  out  1  registered results.
REQ-014 BUSY  out  1  high while a multicycle op is in flight.

Function
REQ-015 Operand A SHALL be RS1_DATA (sel 0), PC_IN (sel 1), FWD1 slice sel-2 (sel 2..FWD_SOURCES+1), zero otherwise; operand B likewise with RS2_DATA, IMM_DATA, FWD2.
REQ-016 Accept SHALL occur on an edge where IN_VALID && IN_READY; IN_READY = (state==IDLE) && !STALL && !CLEAR.
REQ-017 Ops 0-9 and 12-15 SHALL be single-cycle: on the accept edge output registers load, OUT_VALID<=1; reserved ops yield RESULT 0, RD_WRITE_ENABLE_OUT 0.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; shifts use B[$clog2(DATA_WIDTH)-1:0]; SLT signed, SLTU unsigned, result 0/1.
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on accept of MUL/MULHU, capturing A, B, OP, tag and loading counter with DATA_WIDTH.
REQ-020 RUN SHALL perform one unsigned shift-add step per edge on a 2*DATA_WIDTH product, decrementing the counter; RUN->DONE on the edge the counter reaches 0.
REQ-021 DONE->IDLE when !STALL, loading RESULT_OUT (MUL low half, MULHU high half), captured tag, OUT_VALID<=1; DONE SHALL hold while STALL.
REQ-022 Multicycle latency SHALL be DATA_WIDTH+1 edges from accept to OUT_VALID; BUSY high in RUN and DONE.
REQ-023 With STALL high, all output registers SHALL hold; RUN SHALL continue iterating.
REQ-024 On an edge with no accept, no DONE completion, !STALL, OUT_VALID SHALL go 0 (bubble); other outputs hold.
REQ-025 CLEAR SHALL take priority over STALL and accept: next edge state IDLE, OUT_VALID 0, in-flight op discarded.

Reset
REQ-026 RST_N low SHALL immediately force state IDLE, counter 0, OUT_VALID 0, RESULT_OUT 0, RD_ADDRESS_OUT 0, RD_WRITE_ENABLE_OUT 0, BUSY 0.
REQ-027 Reset asserted mid-RUN SHALL discard the operation; no result emitted after release.

Configuration
REQ-028 With EXEC_MULTIPLIER_EN defined, MUL/MULHU SHALL behave per REQ-019..022.
REQ-029 Without EXEC_MULTIPLIER_EN, no multiplier/FSM logic SHALL exist; MUL/MULHU SHALL complete single-cycle as reserved ops, BUSY tied 0.

Verification (DATA_WIDTH=32, FWD_SOURCES=4, EXEC_MULTIPLIER_EN defined)
REQ-030 ADD, A=0xFFFFFFFF, B=1, sels 0/0 -> next edge OUT_VALID 1, RESULT_OUT 0x00000000.
REQ-031 SRA, IN1_SELECT=3 with FWD1 slice1=0x80000000, B=IMM 36 (sel 1) -> RESULT_OUT 0xF8000000.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> IN_READY low, BUSY high, OUT_VALID 1 exactly 33 edges after accept, RESULT_OUT 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-033 MUL 7x6 with STALL held high from edge 30 to 40 -> result 42 emitted on first edge after STALL drops, outputs unchanged during stall.
REQ-034 CLEAR pulsed at edge 10 of a MUL -> OUT_VALID stays 0, IN_READY high next cycle, following ADD 2+3 yields 5.
REQ-035 RST_N low mid-RUN between clock edges -> outputs 0 immediately, no result after release.

Source files
------------

// File: rtl/execute_multicycle_stage.sv
// ---------------------------------------------------------------------------
// execute_multicycle_stage
//
// Execute stage of an in-order pipeline. Selects two operands from the
// register-file / PC / immediate / forwarding sources, evaluates a
// single-cycle ALU op into the output registers, or (optionally) runs an
// iterative shift-add multiplier for MUL / MULHU.
//
// Optional feature macro: EXEC_MULTIPLIER_EN
//   defined   : MUL (10) / MULHU (11) run on a DATA_WIDTH-step shift-add
//               engine, result DATA_WIDTH+1 edges after accept.
//   undefined : no multiplier or FSM; MUL / MULHU complete single-cycle as
//               reserved ops (result 0, no write-enable), BUSY tied 0.
//
// Ports
//   CLK, RST_N                 clock, async active-low reset
//   IN_VALID / IN_READY        upstream handshake
//   STALL, CLEAR               downstream hold, stage flush (CLEAR wins)
//   OP                         operation code
//   RS1_DATA, PC_IN            operand A primary sources (sel 0 / 1)
//   RS2_DATA, IMM_DATA         operand B primary sources (sel 0 / 1)
//   FWD1_DATA, FWD2_DATA       flattened forwarding slices (sel 2..)
//   IN1_SELECT, IN2_SELECT     operand source selects
//   RD_ADDRESS_IN, RD_WRITE_ENABLE_IN   destination tag
//   OUT_VALID, RESULT_OUT, RD_ADDRESS_OUT, RD_WRITE_ENABLE_OUT  registered
//   BUSY                       multicycle op in flight
// ---------------------------------------------------------------------------
module execute_multicycle_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int FWD_SOURCES = 4,
    parameter int SEL_W       = $clog2(FWD_SOURCES + 2)
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    input  logic                              STALL,
    input  logic                              CLEAR,
    input  logic [3:0]                        OP,
    input  logic [DATA_WIDTH-1:0]             RS1_DATA,
    input  logic [DATA_WIDTH-1:0]             PC_IN,
    input  logic [DATA_WIDTH-1:0]             RS2_DATA,
    input  logic [DATA_WIDTH-1:0]             IMM_DATA,
    input  logic [FWD_SOURCES*DATA_WIDTH-1:0] FWD1_DATA,
    input  logic [FWD_SOURCES*DATA_WIDTH-1:0] FWD2_DATA,
    input  logic [SEL_W-1:0]                  IN1_SELECT,
    input  logic [SEL_W-1:0]                  IN2_SELECT,
    input  logic [4:0]                        RD_ADDRESS_IN,
    input  logic                              RD_WRITE_ENABLE_IN,
    output logic                              OUT_VALID,
    output logic [DATA_WIDTH-1:0]             RESULT_OUT,
    output logic [4:0]                        RD_ADDRESS_OUT,
    output logic                              RD_WRITE_ENABLE_OUT,
    output logic                              BUSY
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [SH_W-1:0]       shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_we;
    logic                  idle, accept, is_mul, sc_load;
    logic                  mc_done;
    logic [DATA_WIDTH-1:0] mc_result;
    logic [4:0]            mc_rd;
    logic                  mc_we;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [4:0]            rd_addr_q;
    logic                  rd_we_q;

    // ---------------- operand selection ----------------
    // Selects past the last forwarding slice produce zero.
    always_comb begin
        op_a = '0;
        if (IN1_SELECT == SEL_W'(0))      op_a = RS1_DATA;
        else if (IN1_SELECT == SEL_W'(1)) op_a = PC_IN;
        for (int k = 0; k < FWD_SOURCES; k++)
            if (IN1_SELECT == SEL_W'(k + 2)) op_a = FWD1_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        op_b = '0;
        if (IN2_SELECT == SEL_W'(0))      op_b = RS2_DATA;
        else if (IN2_SELECT == SEL_W'(1)) op_b = IMM_DATA;
        for (int k = 0; k < FWD_SOURCES; k++)
            if (IN2_SELECT == SEL_W'(k + 2)) op_b = FWD2_DATA[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign shamt = op_b[SH_W-1:0];

    // ---------------- single-cycle ALU ----------------
    // MUL/MULHU fall into the default arm; when the multiplier is built they
    // never reach the output through this path.
    always_comb begin
        alu_res = '0;
        alu_we  = RD_WRITE_ENABLE_IN;
        case (OP)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd9:    alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
            default: begin
                alu_res = '0;
                alu_we  = 1'b0;
            end
        endcase
    end

    assign IN_READY = idle && !STALL && !CLEAR;
    assign accept   = IN_VALID && IN_READY;
    assign sc_load  = accept && !is_mul;

`ifdef EXEC_MULTIPLIER_EN
    // ---------------- iterative multiplier ----------------
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SH_W:0]           cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic                    hi_q, hi_d;
    logic [4:0]              tag_rd_q, tag_rd_d;
    logic                    tag_we_q, tag_we_d;

    assign is_mul    = (OP == 4'd10) || (OP == 4'd11);
    assign idle      = (state_q == IDLE);
    assign BUSY      = !idle;
    assign mc_result = hi_q ? prod_q[2*DATA_WIDTH-1:DATA_WIDTH] : prod_q[DATA_WIDTH-1:0];
    assign mc_rd     = tag_rd_q;
    assign mc_we     = tag_we_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        tag_rd_d = tag_rd_q;
        tag_we_d = tag_we_q;
        mc_done  = 1'b0;
        case (state_q)
            IDLE: if (accept && is_mul) begin
                state_d  = RUN;
                cnt_d    = (SH_W+1)'(DATA_WIDTH);
                mcand_d  = {{DATA_WIDTH{1'b0}}, op_a};
                mplier_d = op_b;
                prod_d   = '0;
                hi_d     = OP[0];           // 11 = MULHU
                tag_rd_d = RD_ADDRESS_IN;
                tag_we_d = RD_WRITE_ENABLE_IN;
            end
            // One multiplier bit per edge, LSB first; keeps running under STALL.
            RUN: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - (SH_W+1)'(1);
                if (cnt_q == (SH_W+1)'(1)) state_d = DONE;
            end
            DONE: if (!STALL) begin
                state_d = IDLE;
                mc_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (CLEAR) begin
            state_d = IDLE;
            cnt_d   = '0;
            mc_done = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            hi_q     <= 1'b0;
            tag_rd_q <= '0;
            tag_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            tag_rd_q <= tag_rd_d;
            tag_we_q <= tag_we_d;
        end
    end
`else
    assign is_mul    = 1'b0;
    assign idle      = 1'b1;
    assign BUSY      = 1'b0;
    assign mc_done   = 1'b0;
    assign mc_result = '0;
    assign mc_rd     = '0;
    assign mc_we     = 1'b0;
`endif

    // ---------------- output registers ----------------
    // CLEAR drops the valid; STALL freezes everything; otherwise a finished
    // multiply or a single-cycle accept loads, else a bubble is emitted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
        end else if (CLEAR) begin
            out_valid_q <= 1'b0;
        end else if (!STALL) begin
            if (mc_done) begin
                out_valid_q <= 1'b1;
                result_q    <= mc_result;
                rd_addr_q   <= mc_rd;
                rd_we_q     <= mc_we;
            end else if (sc_load) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                rd_addr_q   <= RD_ADDRESS_IN;
                rd_we_q     <= alu_we;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign OUT_VALID           = out_valid_q;
    assign RESULT_OUT          = result_q;
    assign RD_ADDRESS_OUT      = rd_addr_q;
    assign RD_WRITE_ENABLE_OUT = rd_we_q;

endmodule

// File: tb/tb_execute_multicycle_stage.sv
module tb_execute_multicycle_stage;
    localparam int DW = 32;
    localparam int FS = 4;
    localparam int SW = 3;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           IN_VALID, IN_READY, STALL, CLEAR;
    logic [3:0]     OP;
    logic [DW-1:0]  RS1_DATA, PC_IN, RS2_DATA, IMM_DATA;
    logic [FS*DW-1:0] FWD1_DATA, FWD2_DATA;
    logic [SW-1:0]  IN1_SELECT, IN2_SELECT;
    logic [4:0]     RD_ADDRESS_IN;
    logic           RD_WRITE_ENABLE_IN;
    logic           OUT_VALID;
    logic [DW-1:0]  RESULT_OUT;
    logic [4:0]     RD_ADDRESS_OUT;
    logic           RD_WRITE_ENABLE_OUT;
    logic           BUSY;

    execute_multicycle_stage #(.DATA_WIDTH(DW), .FWD_SOURCES(FS), .SEL_W(SW)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .STALL(STALL), .CLEAR(CLEAR), .OP(OP),
        .RS1_DATA(RS1_DATA), .PC_IN(PC_IN), .RS2_DATA(RS2_DATA), .IMM_DATA(IMM_DATA),
        .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
        .IN1_SELECT(IN1_SELECT), .IN2_SELECT(IN2_SELECT),
        .RD_ADDRESS_IN(RD_ADDRESS_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
        .OUT_VALID(OUT_VALID), .RESULT_OUT(RESULT_OUT), .RD_ADDRESS_OUT(RD_ADDRESS_OUT),
        .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] res;
        logic [4:0]    rd;
        logic          we;
    } exp_t;

    exp_t sbq[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] r, input logic [4:0] rd, input logic we);
        exp_t e;
        e.res = r; e.rd = rd; e.we = we;
        sbq.push_back(e);
    endtask

    // One clock edge; a fresh output (valid on an unstalled edge) is
    // compared against the head of the scoreboard.
    task automatic tick();
        logic st, cl;
        exp_t e;
        st = STALL;
        cl = CLEAR;
        @(posedge CLK);
        #1;
        if (OUT_VALID === 1'b1 && !st && !cl) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", {63'd0, OUT_VALID}, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_result", RESULT_OUT, e.res);
                chk("sb_rd", RD_ADDRESS_OUT, e.rd);
                chk("sb_we", RD_WRITE_ENABLE_OUT, e.we);
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] rd,
                         input bit do_push, input logic [DW-1:0] er, input logic ewe);
        OP = op; IN1_SELECT = s1; IN2_SELECT = s2;
        RS1_DATA = a; RS2_DATA = b; RD_ADDRESS_IN = rd; RD_WRITE_ENABLE_IN = 1'b1;
        IN_VALID = 1'b1;
        if (do_push) push(er, rd, ewe);
        tick();
        IN_VALID = 1'b0;
    endtask

    initial begin
        int  n, vcnt;
        bit  got;
        RST_N = 1'b1;
        IN_VALID = 0; STALL = 0; CLEAR = 0; OP = 0;
        RS1_DATA = 0; RS2_DATA = 0; PC_IN = 32'h0000_1000; IMM_DATA = 32'd36;
        FWD1_DATA = {32'h3333_3333, 32'h2222_2222, 32'h8000_0000, 32'h1111_1111};
        FWD2_DATA = {32'h0000_0100, 32'h0000_0020, 32'h0000_0010, 32'h0000_0001};
        IN1_SELECT = 0; IN2_SELECT = 0; RD_ADDRESS_IN = 0; RD_WRITE_ENABLE_IN = 0;

        // reset state
        #1 RST_N = 1'b0;
        #2;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_result", RESULT_OUT, 0);
        chk("rst_rd", RD_ADDRESS_OUT, 0);
        chk("rst_we", RD_WRITE_ENABLE_OUT, 0);
        chk("rst_busy", BUSY, 0);
        @(negedge CLK) RST_N = 1'b1;
        #1 chk("rst_ready", IN_READY, 1);

        // single-cycle ops, back to back
        issue(4'd0, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1, 32'h0000_0000, 1);
        chk("add_wrap_valid", OUT_VALID, 1);
        issue(4'd1, 0, 0, 32'd3, 32'd5, 5'd6, 1, 32'hFFFF_FFFE, 1);
        tick();
        chk("bubble_valid", OUT_VALID, 0);
        chk("bubble_hold", RESULT_OUT, 32'hFFFF_FFFE);
        issue(4'd2, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd1, 1, 32'h00F0_F000, 1);
        issue(4'd3, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd2, 1, 32'hFFF0_FFF0, 1);
        issue(4'd4, 0, 0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd3, 1, 32'hFF00_0FF0, 1);
        issue(4'd5, 0, 0, 32'd1, 32'd33, 5'd4, 1, 32'd2, 1);
        issue(4'd6, 0, 0, 32'h8000_0000, 32'd31, 5'd4, 1, 32'd1, 1);
        issue(4'd8, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd8, 1, 32'd1, 1);
        issue(4'd8, 0, 0, 32'd1, 32'hFFFF_FFFF, 5'd8, 1, 32'd0, 1);
        issue(4'd9, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd9, 1, 32'd0, 1);
        issue(4'd13, 0, 0, 32'd5, 32'd6, 5'd7, 1, 32'd0, 0);
        // operand selects: forwarding, PC/IMM, out of range
        issue(4'd7, 3'd3, 3'd1, 32'h1234_5678, 32'd1, 5'd10, 1, 32'hF800_0000, 1);
        issue(4'd0, 3'd1, 3'd5, 32'h1234_5678, 32'd1, 5'd11, 1, 32'h0000_1100, 1);
        issue(4'd0, 3'd6, 3'd7, 32'h1234_5678, 32'd1, 5'd12, 1, 32'd0, 1);

        // stall holds outputs and blocks accept
        issue(4'd0, 0, 0, 32'd2, 32'd3, 5'd9, 1, 32'd5, 1);
        STALL = 1; IN_VALID = 1; OP = 4'd0; RS1_DATA = 32'd10; RS2_DATA = 32'd20; RD_ADDRESS_IN = 5'd3;
        #1 chk("stall_ready", IN_READY, 0);
        tick();
        chk("stall_valid_hold", OUT_VALID, 1);
        chk("stall_result_hold", RESULT_OUT, 32'd5);
        tick();
        chk("stall_rd_hold", RD_ADDRESS_OUT, 5'd9);
        STALL = 0;
        push(32'd30, 5'd3, 1);
        tick();
        IN_VALID = 0;

        // clear blocks accept and kills valid
        CLEAR = 1; IN_VALID = 1;
        #1 chk("clear_ready", IN_READY, 0);
        tick();
        chk("clear_valid", OUT_VALID, 0);
        CLEAR = 0; IN_VALID = 0;

`ifdef EXEC_MULTIPLIER_EN
        // MULHU latency and result
        issue(4'd11, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1, 32'hFFFF_FFFE, 1);
        chk("mulhu_busy", BUSY, 1);
        chk("mulhu_ready", IN_READY, 0);
        chk("mulhu_valid_early", OUT_VALID, 0);
        got = 0; n = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (OUT_VALID) begin got = 1; n = i; end
        end
        chk("mulhu_latency", n, 33);
        chk("mulhu_busy_after", BUSY, 0);

        issue(4'd10, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 1, 32'h0000_0001, 1);
        got = 0; n = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (OUT_VALID) begin got = 1; n = i; end
        end
        chk("mul_latency", n, 33);

        // MUL 7x6 with STALL on edges 30..40
        issue(4'd10, 0, 0, 32'd7, 32'd6, 5'd22, 1, 32'd42, 1);
        got = 0; n = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            if (i == 30) STALL = 1;
            if (i == 41) STALL = 0;
            tick();
            if (i >= 30 && i <= 40) begin
                chk("mul_stall_valid", OUT_VALID, 0);
                chk("mul_stall_result", RESULT_OUT, 32'd1);
            end
            if (OUT_VALID) begin got = 1; n = i; end
        end
        chk("mul_stall_edge", n, 41);

        // CLEAR at edge 10 of a MUL
        issue(4'd10, 0, 0, 32'd7, 32'd6, 5'd23, 0, 32'd0, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) CLEAR = 1;
            tick();
        end
        CLEAR = 0;
        #1;
        chk("clear_mul_valid", OUT_VALID, 0);
        chk("clear_mul_ready", IN_READY, 1);
        chk("clear_mul_busy", BUSY, 0);
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (OUT_VALID) vcnt++;
        end
        chk("clear_mul_no_result", vcnt, 0);
        issue(4'd0, 0, 0, 32'd2, 32'd3, 5'd13, 1, 32'd5, 1);

        // reset mid-RUN
        issue(4'd10, 0, 0, 32'd9, 32'd9, 5'd14, 0, 32'd0, 0);
        repeat (5) tick();
        chk("mid_run_busy", BUSY, 1);
`else
        // without the multiplier MUL/MULHU are reserved single-cycle ops
        issue(4'd10, 0, 0, 32'd7, 32'd6, 5'd22, 1, 32'd0, 0);
        chk("nomul_busy", BUSY, 0);
        chk("nomul_ready", IN_READY, 1);
        issue(4'd11, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 1, 32'd0, 0);
        issue(4'd0, 0, 0, 32'd2, 32'd3, 5'd13, 1, 32'd5, 1);
        tick();
`endif
        // asynchronous reset between edges
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_result", RESULT_OUT, 0);
        chk("async_rst_rd", RD_ADDRESS_OUT, 0);
        chk("async_rst_we", RD_WRITE_ENABLE_OUT, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_valid", OUT_VALID, 0);
        @(negedge CLK) RST_N = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (OUT_VALID) vcnt++;
        end
        chk("post_rst_no_result", vcnt, 0);

        chk("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
